fft_stage_sequencer: RTL and testbench

- Controller for an in-place radix-2 DIT FFT built around one pipelined CORDIC butterfly and one dual-port sample memory.
- On start, walks all log2(N) stages. Each cycle it issues one butterfly: two read addresses plus a twiddle angle.
- Tracks each issued butterfly through the butterfly pipeline latency and generates the matching write-back addresses.
- Drains the pipeline between stages so that no stage reads data the previous stage has not yet written.

---
 rtl/fft_stage_sequencer.sv | 147 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Issue/write-back address sequencer for an in-place radix-2 DIT FFT around a
// pipelined butterfly: one butterfly read per cycle, writes tracked BFLY_LAT cycles later.
module fft_stage_sequencer #(
    parameter int N_LOG2    = 4,
    parameter int FRAC_BITS = 15,
    parameter int BFLY_LAT  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_LOG2-1:0]    stage_o,
    output logic                 rd_en_o,
    output logic [N_LOG2-1:0]    rd_addr_a_o,
    output logic [N_LOG2-1:0]    rd_addr_b_o,
    output logic [FRAC_BITS:0]   twid_o,
    output logic                 wr_en_o,
    output logic [N_LOG2-1:0]    wr_addr_a_o,
    output logic [N_LOG2-1:0]    wr_addr_b_o
);

    localparam int AW   = N_LOG2;
    localparam int TW   = FRAC_BITS + 1;
    localparam int KW   = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
    localparam int CW   = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam int HALF = 1 << (N_LOG2 - 1);

    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
    localparam logic [CW-1:0] D_LAST = CW'(BFLY_LAT - 1);
    localparam logic [AW-1:0] S_LAST = AW'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t         state, state_n;
    logic [AW-1:0]  s, s_n;
    logic [KW-1:0]  k, k_n;
    logic [CW-1:0]  dcnt, dcnt_n;

    logic [AW-1:0]  k_ext, span, mask, j;
    logic [AW-1:0]  addr_a_n, addr_b_n;
    logic [TW-1:0]  twid_n;
    int             shamt;

    // Entry i holds {valid, addr_a, addr_b} of the read issued i+1 cycles ago.
    logic [2*AW:0]  pipe [BFLY_LAT];

    always_comb begin
        state_n = state;
        s_n     = s;
        k_n     = k;
        dcnt_n  = dcnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = ISSUE;
                    s_n     = '0;
                    k_n     = '0;
                end
            end
            ISSUE: begin
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    dcnt_n  = '0;
                end else begin
                    k_n = k + KW'(1);
                end
            end
            DRAIN: begin
                // Drain ends on the cycle the stage's last result is written.
                if (dcnt == D_LAST) begin
                    if (s == S_LAST) begin
                        state_n = FINISH;
                    end else begin
                        state_n = ISSUE;
                        s_n     = s + AW'(1);
                        k_n     = '0;
                    end
                end else begin
                    dcnt_n = dcnt + CW'(1);
                end
            end
            FINISH: begin
                state_n = IDLE;
                s_n     = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Butterfly k of stage s: low s bits of k stay in place, upper bits move up one.
    always_comb begin
        k_ext    = AW'(k_n);
        span     = AW'(1) << s_n;
        mask     = span - AW'(1);
        j        = k_ext & mask;
        addr_a_n = ((k_ext & ~mask) << 1) | j;
        addr_b_n = addr_a_n | span;
        shamt    = FRAC_BITS - int'(s_n);
        twid_n   = TW'(0) - (TW'(j) << shamt);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            s           <= '0;
            k           <= '0;
            dcnt        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            twid_o      <= '0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            k       <= k_n;
            dcnt    <= dcnt_n;
            busy_o  <= (state_n == ISSUE) || (state_n == DRAIN);
            done_o  <= (state_n == FINISH);
            rd_en_o <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                rd_addr_a_o <= addr_a_n;
                rd_addr_b_o <= addr_b_n;
                twid_o      <= twid_n;
            end else begin
                rd_addr_a_o <= '0;
                rd_addr_b_o <= '0;
                twid_o      <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BFLY_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
            for (int i = 1; i < BFLY_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign stage_o = s;
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = pipe[BFLY_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: an 8-point/latency-2 instance and a 16-point/latency-16
// instance checked every cycle against a schedule computed from stage/butterfly arithmetic.
module tb_fft_stage_sequencer;

    localparam int FB   = 15;
    localparam int NP_A = 3 * (4 + 2);
    localparam int NP_B = 4 * (8 + 16);

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;

    logic        busy_a, done_a, rd_en_a, wr_en_a;
    logic [2:0]  stage_a, ra_a, rb_a, wa_a, wb_a;
    logic [15:0] tw_a;
    logic        busy_b, done_b, rd_en_b, wr_en_b;
    logic [3:0]  stage_b, ra_b, rb_b, wa_b, wb_b;
    logic [15:0] tw_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_a   = -1;
    int t_b   = -1;
    int conflicts = 0;
    int s0;

    int rd_log_a[$], done_log_a[$], rd_log_b[$], done_log_b[$];
    logic [21:0] exp_q[$];
    logic [21:0] sb_x;
    bit sb_on = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N_LOG2(3), .FRAC_BITS(FB), .BFLY_LAT(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .stage_o(stage_a), .rd_en_o(rd_en_a), .rd_addr_a_o(ra_a), .rd_addr_b_o(rb_a),
        .twid_o(tw_a), .wr_en_o(wr_en_a), .wr_addr_a_o(wa_a), .wr_addr_b_o(wb_a)
    );

    fft_stage_sequencer #(.N_LOG2(4), .FRAC_BITS(FB), .BFLY_LAT(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .stage_o(stage_b), .rd_en_o(rd_en_b), .rd_addr_a_o(ra_b), .rd_addr_b_o(rb_b),
        .twid_o(tw_b), .wr_en_o(wr_en_b), .wr_addr_a_o(wa_b), .wr_addr_b_o(wb_b)
    );

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    typedef struct packed {
        bit rd;
        int stage;
        int a;
        int b;
        int tw;
    } rd_t;

    // Expected read at cycle t of a run (t=0 is the first read cycle).
    function automatic rd_t rd_at(input int nl, input int lat, input int t);
        rd_t r;
        int h, p, pos, s, span, j, grp;
        r = '0;
        h = 1 << (nl - 1);
        p = h + lat;
        if (t < 0 || t >= nl * p) return r;
        pos = t % p;
        if (pos >= h) return r;
        s     = t / p;
        span  = 1 << s;
        j     = pos % span;
        grp   = pos / span;
        r.rd    = 1'b1;
        r.stage = s;
        r.a     = grp * 2 * span + j;
        r.b     = r.a + span;
        r.tw    = (65536 - j * (1 << (FB - s))) % 65536;
        return r;
    endfunction

    task automatic cmp_dut(input string tag, input int nl, input int lat, input int t,
                           input int busy, input int done, input int rd_en, input int wr_en,
                           input int stage, input int ra, input int rb, input int tw,
                           input int wa, input int wb);
        rd_t e, w;
        int np;
        np = nl * ((1 << (nl - 1)) + lat);
        e  = rd_at(nl, lat, t);
        w  = rd_at(nl, lat, t - lat);
        chk({tag, ".busy"},  busy,  int'(t >= 0 && t < np));
        chk({tag, ".done"},  done,  int'(t == np));
        chk({tag, ".rd_en"}, rd_en, int'(e.rd));
        chk({tag, ".wr_en"}, wr_en, int'(w.rd));
        if (e.rd) begin
            chk({tag, ".stage"}, stage, e.stage);
            chk({tag, ".rd_a"},  ra,    e.a);
            chk({tag, ".rd_b"},  rb,    e.b);
            chk({tag, ".twid"},  tw,    e.tw);
        end
        if (w.rd) begin
            chk({tag, ".wr_a"}, wa, w.a);
            chk({tag, ".wr_b"}, wb, w.b);
        end
    endtask

    // Run-position trackers: start accepted only when idle; FINISH cycle is t==NP.
    always @(posedge clk or posedge rst) begin
        if (rst) t_a = -1;
        else if (t_a < 0) begin
            if (start_a) t_a = 0;
        end else if (t_a >= NP_A) t_a = -1;
        else t_a++;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) t_b = -1;
        else if (t_b < 0) begin
            if (start_b) t_b = 0;
        end else if (t_b >= NP_B) t_b = -1;
        else t_b++;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmp_dut("a", 3, 2, t_a, busy_a, done_a, rd_en_a, wr_en_a, stage_a, ra_a, rb_a, tw_a,
                wa_a, wb_a);
        cmp_dut("b", 4, 16, t_b, busy_b, done_b, rd_en_b, wr_en_b, stage_b, ra_b, rb_b, tw_b,
                wa_b, wb_b);
    end

    always @(negedge clk) begin
        if (rd_en_a) begin
            rd_log_a.push_back(cyc);
            if (sb_on) begin
                if (exp_q.size() == 0) chk("sb_extra_rd", 1, 0);
                else begin
                    sb_x = exp_q.pop_front();
                    chk("sb_rd", int'({ra_a, rb_a, tw_a}), int'(sb_x));
                end
            end
        end
        if (done_a) done_log_a.push_back(cyc);
        if (rd_en_b) rd_log_b.push_back(cyc);
        if (done_b) done_log_b.push_back(cyc);
        if (rd_en_a && wr_en_a && (ra_a == wa_a || ra_a == wb_a || rb_a == wa_a || rb_a == wb_a))
            conflicts++;
        if (rd_en_b && wr_en_b && (ra_b == wa_b || ra_b == wb_b || rb_b == wa_b || rb_b == wb_b))
            conflicts++;
    end

    task automatic wait_done(input bit which, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? done_b : done_a) === 1'b1) return;
        end
        chk(which ? "timeout_b" : "timeout_a", 0, 1);
    endtask

    task automatic pulse_start_a;
        @(posedge clk);
        #1;
        s0 = cyc;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        // Literal read sequence of the 8-point transform: {a, b, twid}.
        exp_q.push_back({3'd0, 3'd1, 16'd0});
        exp_q.push_back({3'd2, 3'd3, 16'd0});
        exp_q.push_back({3'd4, 3'd5, 16'd0});
        exp_q.push_back({3'd6, 3'd7, 16'd0});
        exp_q.push_back({3'd0, 3'd2, 16'd0});
        exp_q.push_back({3'd1, 3'd3, 16'd49152});
        exp_q.push_back({3'd4, 3'd6, 16'd0});
        exp_q.push_back({3'd5, 3'd7, 16'd49152});
        exp_q.push_back({3'd0, 3'd4, 16'd0});
        exp_q.push_back({3'd1, 3'd5, 16'd57344});
        exp_q.push_back({3'd2, 3'd6, 16'd49152});
        exp_q.push_back({3'd3, 3'd7, 16'd40960});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_stage", stage_a, 0);
        chk("rst_twid", tw_a, 0);
        rst = 1'b0;

        // Run 1: both instances; a held-high start during busy must be ignored.
        sb_on = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_a = 1'b0;
        wait_done(1'b0, 100);
        wait_done(1'b1, 200);
        @(posedge clk);
        #1;
        sb_on = 1'b0;
        chk("sb_left", exp_q.size(), 0);
        chk("a_reads", rd_log_a.size(), 12);
        chk("a_dones", done_log_a.size(), 1);
        if (rd_log_a.size() >= 5) begin
            chk("a_first_rd_lat", rd_log_a[0] - s0, 1);
            chk("a_stage1_gap", rd_log_a[4] - rd_log_a[0], 6);
            if (done_log_a.size() >= 1) chk("a_done_time", done_log_a[0] - rd_log_a[0], 18);
        end
        chk("b_reads", rd_log_b.size(), 32);
        chk("b_dones", done_log_b.size(), 1);
        if (rd_log_b.size() >= 1 && done_log_b.size() >= 1)
            chk("b_done_time", done_log_b[0] - rd_log_b[0], 96);

        // Run 2: abort with reset during stage 1.
        rd_log_a.delete();
        done_log_a.delete();
        pulse_start_a();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (stage_a == 3'd1 && rd_en_a) break;
        end
        chk("a_reached_stage1", int'(stage_a), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_rd_en", rd_en_a, 0);
        chk("abort_wr_en", wr_en_a, 0);
        chk("abort_stage", stage_a, 0);
        chk("abort_rd_a", ra_a, 0);
        chk("abort_rd_b", rb_a, 0);
        chk("abort_twid", tw_a, 0);
        chk("abort_done", done_a, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);

        // Run 3: full sequence after the abort.
        rd_log_a.delete();
        done_log_a.delete();
        pulse_start_a();
        wait_done(1'b0, 100);
        @(posedge clk);
        #1;
        chk("re_reads", rd_log_a.size(), 12);
        if (rd_log_a.size() >= 1 && done_log_a.size() >= 1) begin
            chk("re_first_rd_lat", rd_log_a[0] - s0, 1);
            chk("re_done_time", done_log_a[0] - rd_log_a[0], 18);
        end
        repeat (3) @(posedge clk);
        chk("rd_wr_conflicts", conflicts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
